// File: rtl/ic_pkg.sv
// Shared constants and FSM state encoding for the input-capture gate timer.
package ic_pkg;

    localparam int unsigned GATE_W_DEF = 24;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StClear  = 3'd1,
        StGate   = 3'd2,
        StSettle = 3'd3,
        StHold   = 3'd4
    } gate_state_e;

endpackage

// File: rtl/ic_gate_timer.sv
// Gate-window timer around an external capture counter: clear, count for a fixed window, latch.
// Optional continuous mode (macro IC_GATE_CONT_EN) restarts the window after each acknowledge.
module ic_gate_timer
    import ic_pkg::*;
#(
    parameter int unsigned GATE_W = GATE_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              i_sysclk,
    input  logic              i_sysrst_n,
    input  logic              i_start,
    input  logic [GATE_W-1:0] i_gate_len,
    input  logic              i_ic_flg,
    input  logic [CNT_W-1:0]  i_cnt_data,
    input  logic              i_rd_ack,
    output logic              o_clr,
    output logic              o_cnt_en,
    output logic              o_busy,
    output logic              o_res_valid,
    output logic [CNT_W-1:0]  o_res_data,
    output logic              o_res_ovf
);

    localparam logic [GATE_W-1:0] GateOne = {{(GATE_W-1){1'b0}}, 1'b1};

    gate_state_e       state_q;
    logic [GATE_W-1:0] gate_len_q;
    logic [GATE_W-1:0] gate_cnt_q;
    logic              ovf_q;
    logic              ovf_hit;
    logic [GATE_W-1:0] gate_len_eff;

    // An increment that lands on zero means the capture counter just wrapped.
    assign ovf_hit      = i_ic_flg && (i_cnt_data == '0);
    assign gate_len_eff = (i_gate_len == '0) ? GateOne : i_gate_len;

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            state_q     <= StIdle;
            gate_len_q  <= '0;
            gate_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            o_clr       <= 1'b0;
            o_cnt_en    <= 1'b0;
            o_busy      <= 1'b0;
            o_res_valid <= 1'b0;
            o_res_data  <= '0;
            o_res_ovf   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        gate_len_q <= gate_len_eff;
                        o_clr      <= 1'b1;
                        o_busy     <= 1'b1;
                        state_q    <= StClear;
                    end
                end
                StClear: begin
                    o_clr      <= 1'b0;
                    ovf_q      <= 1'b0;
                    gate_cnt_q <= gate_len_q;
                    o_cnt_en   <= 1'b1;
                    state_q    <= StGate;
                end
                StGate: begin
                    if (ovf_hit) begin
                        ovf_q <= 1'b1;
                    end
                    gate_cnt_q <= gate_cnt_q - GateOne;
                    if (gate_cnt_q == GateOne) begin
                        o_cnt_en <= 1'b0;
                        state_q  <= StSettle;
                    end
                end
                StSettle: begin
                    // Last in-gate edge only reaches i_cnt_data during this cycle.
                    ovf_q       <= ovf_q | ovf_hit;
                    o_res_ovf   <= ovf_q | ovf_hit;
                    o_res_data  <= i_cnt_data;
                    o_res_valid <= 1'b1;
                    state_q     <= StHold;
                end
                StHold: begin
                    if (i_rd_ack) begin
                        o_res_valid <= 1'b0;
`ifdef IC_GATE_CONT_EN
                        o_clr       <= 1'b1;
                        state_q     <= StClear;
`else
                        o_busy      <= 1'b0;
                        state_q     <= StIdle;
`endif
                    end
                end
                default: begin
                    o_clr       <= 1'b0;
                    o_cnt_en    <= 1'b0;
                    o_busy      <= 1'b0;
                    o_res_valid <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

endmodule
